// File: rtl/cpu_display_scanner_if.sv
// rtl/cpu_display_scanner_if.sv - host read port of the display scanner (optional CHANGE_FLAG_EN adds rd_changed)
interface cpu_display_scanner_if;
   logic        rd_en;
   logic        rd_sel;
   logic [4:0]  rd_idx;
   logic [31:0] rd_data;
   logic        rd_valid;
`ifdef CHANGE_FLAG_EN
   logic        rd_changed;

   modport master (output rd_en, output rd_sel, output rd_idx,
                   input rd_data, input rd_valid, input rd_changed);
   modport slave  (input rd_en, input rd_sel, input rd_idx,
                   output rd_data, output rd_valid, output rd_changed);
`else
   modport master (output rd_en, output rd_sel, output rd_idx,
                   input rd_data, input rd_valid);
   modport slave  (input rd_en, input rd_sel, input rd_idx,
                   output rd_data, output rd_valid);
`endif
endinterface

// File: rtl/cpu_display_scanner.sv
// rtl/cpu_display_scanner.sv - scans CPU register/memory display port into a shadow buffer (optional CHANGE_FLAG_EN)
module cpu_display_scanner #(
   parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
   parameter int          MEM_WORDS = 8,
   parameter int          SETTLE    = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        scan_start,
   input  logic        scan_cont,
   output logic [4:0]  rf_addr,
   output logic [31:0] mem_addr,
   input  logic [31:0] rf_data,
   input  logic [31:0] mem_data,
   input  logic [2:0]  display_state,
   output logic        busy,
   output logic        scan_done,
   output logic [15:0] scan_count,
   output logic [2:0]  snap_state,
   cpu_display_scanner_if.slave host
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RF_SET   = 3'd1;
   localparam logic [2:0] S_RF_WAIT  = 3'd2;
   localparam logic [2:0] S_RF_CAP   = 3'd3;
   localparam logic [2:0] S_MEM_SET  = 3'd4;
   localparam logic [2:0] S_MEM_WAIT = 3'd5;
   localparam logic [2:0] S_MEM_CAP  = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   localparam logic [4:0] MEM_LAST  = 5'(MEM_WORDS - 1);
   localparam logic [5:0] MEM_CNT   = 6'(MEM_WORDS);
   localparam bit         HAS_WAIT  = (SETTLE > 0);
   localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(SETTLE - 1) : 4'd0;

   logic [2:0]  state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [3:0]  wait_q, wait_d;
   logic [4:0]  rf_addr_q, rf_addr_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        busy_q, busy_d;
   logic        scan_done_q, scan_done_d;
   logic [15:0] scan_count_q, scan_count_d;
   logic [2:0]  snap_state_q, snap_state_d;
   logic        cap_rf, cap_mem;

   // Memory buffer is always 32 deep; entries past MEM_WORDS are never written and stay 0.
   logic [31:0] rf_buf_q  [32];
   logic [31:0] rf_buf_d  [32];
   logic [31:0] mem_buf_q [32];
   logic [31:0] mem_buf_d [32];
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        rd_mem_ok;
`ifdef CHANGE_FLAG_EN
   logic [31:0] rf_chg_q, rf_chg_d;
   logic [31:0] mem_chg_q, mem_chg_d;
   logic        rd_changed_q, rd_changed_d;
`endif

   function automatic logic [31:0] mem_addr_of(input logic [4:0] i);
      return MEM_BASE + {25'd0, i, 2'b00};
   endfunction

   // Scan sequencer: addresses are loaded on entry to *_SET so they are stable for SET, WAIT and CAP.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      wait_d       = wait_q;
      rf_addr_d    = rf_addr_q;
      mem_addr_d   = mem_addr_q;
      busy_d       = busy_q;
      scan_done_d  = 1'b0;
      scan_count_d = scan_count_q;
      snap_state_d = snap_state_q;
      cap_rf       = 1'b0;
      cap_mem      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (scan_start || scan_cont) begin
               state_d      = S_RF_SET;
               snap_state_d = display_state;
               busy_d       = 1'b1;
               idx_d        = 5'd0;
               rf_addr_d    = 5'd0;
            end
         end
         S_RF_SET: begin
            if (HAS_WAIT) begin
               wait_d  = WAIT_INIT;
               state_d = S_RF_WAIT;
            end else begin
               state_d = S_RF_CAP;
            end
         end
         S_RF_WAIT: begin
            if (wait_q == 4'd0) state_d = S_RF_CAP;
            else                wait_d  = wait_q - 4'd1;
         end
         S_RF_CAP: begin
            cap_rf = 1'b1;
            if (idx_q == 5'd31) begin
               idx_d      = 5'd0;
               mem_addr_d = mem_addr_of(5'd0);
               state_d    = S_MEM_SET;
            end else begin
               idx_d     = idx_q + 5'd1;
               rf_addr_d = idx_q + 5'd1;
               state_d   = S_RF_SET;
            end
         end
         S_MEM_SET: begin
            if (HAS_WAIT) begin
               wait_d  = WAIT_INIT;
               state_d = S_MEM_WAIT;
            end else begin
               state_d = S_MEM_CAP;
            end
         end
         S_MEM_WAIT: begin
            if (wait_q == 4'd0) state_d = S_MEM_CAP;
            else                wait_d  = wait_q - 4'd1;
         end
         S_MEM_CAP: begin
            cap_mem = 1'b1;
            if (idx_q == MEM_LAST) begin
               idx_d   = 5'd0;
               state_d = S_DONE;
            end else begin
               idx_d      = idx_q + 5'd1;
               mem_addr_d = mem_addr_of(idx_q + 5'd1);
               state_d    = S_MEM_SET;
            end
         end
         S_DONE: begin
            scan_done_d  = 1'b1;
            scan_count_d = scan_count_q + 16'd1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Shadow buffer write on capture.
   always_comb begin
      rf_buf_d  = rf_buf_q;
      mem_buf_d = mem_buf_q;
      if (cap_rf)  rf_buf_d[idx_q]  = rf_data;
      if (cap_mem) mem_buf_d[idx_q] = mem_data;
   end

   // Host read port: reads the pre-capture contents, so a same-cycle capture is not visible yet.
   always_comb begin
      rd_valid_d = host.rd_en;
      rd_data_d  = rd_data_q;
      rd_mem_ok  = ({1'b0, host.rd_idx} < MEM_CNT);
      if (host.rd_en) begin
         if (host.rd_sel) rd_data_d = rd_mem_ok ? mem_buf_q[host.rd_idx] : 32'h0;
         else             rd_data_d = rf_buf_q[host.rd_idx];
      end
   end

`ifdef CHANGE_FLAG_EN
   // Change flags: read clears first, then a differing capture sets, so an unseen change is never lost.
   always_comb begin
      rf_chg_d     = rf_chg_q;
      mem_chg_d    = mem_chg_q;
      rd_changed_d = rd_changed_q;
      if (host.rd_en) begin
         if (host.rd_sel) begin
            rd_changed_d = rd_mem_ok ? mem_chg_q[host.rd_idx] : 1'b0;
            mem_chg_d[host.rd_idx] = 1'b0;
         end else begin
            rd_changed_d = rf_chg_q[host.rd_idx];
            rf_chg_d[host.rd_idx] = 1'b0;
         end
      end
      if (cap_rf && (rf_data != rf_buf_q[idx_q]))    rf_chg_d[idx_q]  = 1'b1;
      if (cap_mem && (mem_data != mem_buf_q[idx_q])) mem_chg_d[idx_q] = 1'b1;
   end
`endif

   // State registers with synchronous active-low reset; reset also clears the buffer.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         idx_q        <= 5'd0;
         wait_q       <= 4'd0;
         rf_addr_q    <= 5'd0;
         mem_addr_q   <= MEM_BASE;
         busy_q       <= 1'b0;
         scan_done_q  <= 1'b0;
         scan_count_q <= 16'd0;
         snap_state_q <= 3'd0;
         rd_data_q    <= 32'h0;
         rd_valid_q   <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            rf_buf_q[i]  <= 32'h0;
            mem_buf_q[i] <= 32'h0;
         end
`ifdef CHANGE_FLAG_EN
         rf_chg_q     <= 32'h0;
         mem_chg_q    <= 32'h0;
         rd_changed_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         wait_q       <= wait_d;
         rf_addr_q    <= rf_addr_d;
         mem_addr_q   <= mem_addr_d;
         busy_q       <= busy_d;
         scan_done_q  <= scan_done_d;
         scan_count_q <= scan_count_d;
         snap_state_q <= snap_state_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         rf_buf_q     <= rf_buf_d;
         mem_buf_q    <= mem_buf_d;
`ifdef CHANGE_FLAG_EN
         rf_chg_q     <= rf_chg_d;
         mem_chg_q    <= mem_chg_d;
         rd_changed_q <= rd_changed_d;
`endif
      end
   end

   assign rf_addr       = rf_addr_q;
   assign mem_addr      = mem_addr_q;
   assign busy          = busy_q;
   assign scan_done     = scan_done_q;
   assign scan_count    = scan_count_q;
   assign snap_state    = snap_state_q;
   assign host.rd_data  = rd_data_q;
   assign host.rd_valid = rd_valid_q;
`ifdef CHANGE_FLAG_EN
   assign host.rd_changed = rd_changed_q;
`endif

endmodule

// File: tb/tb_cpu_display_scanner.sv
// tb/tb_cpu_display_scanner.sv - scoreboard bench for cpu_display_scanner
module tb_cpu_display_scanner;
   localparam logic [31:0] BASE = 32'h1000_0040;
   localparam int MW = 8;
   localparam int ST = 1;
   localparam int PASS_LEN = (32 + MW) * (ST + 2) + 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        scan_start = 1'b0;
   logic        scan_cont = 1'b0;
   logic [4:0]  rf_addr;
   logic [31:0] mem_addr;
   logic [31:0] rf_data;
   logic [31:0] mem_data;
   logic [2:0]  display_state = 3'd0;
   logic        busy;
   logic        scan_done;
   logic [15:0] scan_count;
   logic [2:0]  snap_state;

   cpu_display_scanner_if hif ();

   cpu_display_scanner #(.MEM_BASE(BASE), .MEM_WORDS(MW), .SETTLE(ST)) dut (
      .clk(clk), .resetn(resetn), .scan_start(scan_start), .scan_cont(scan_cont),
      .rf_addr(rf_addr), .mem_addr(mem_addr), .rf_data(rf_data), .mem_data(mem_data),
      .display_state(display_state), .busy(busy), .scan_done(scan_done),
      .scan_count(scan_count), .snap_state(snap_state), .host(hif.slave)
   );

   always #5 clk = ~clk;

   // CPU display port model
   logic [31:0] rf_model [32];
   logic [31:0] mem_model [MW];
   logic [31:0] moff;
   always_comb begin
      rf_data = rf_model[rf_addr];
      moff = mem_addr - BASE;
      if (moff[1:0] == 2'b00 && moff < 32'(4 * MW)) mem_data = mem_model[moff[4:2]];
      else                                         mem_data = 32'hDEAD_BEEF;
   end

   typedef struct {
      logic [31:0] data;
      logic        chg;
      string       name;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: every rd_valid pops one expected entry.
   always @(negedge clk) begin
      if (hif.rd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_rd_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, hif.rd_data, e.data);
`ifdef CHANGE_FLAG_EN
            check({e.name, "_chg"}, {31'd0, hif.rd_changed}, {31'd0, e.chg});
`endif
         end
      end
   end

   task automatic host_read(input logic sel, input logic [4:0] idx, input logic [31:0] exp,
                            input logic chg, input string name);
      exp_t e;
      @(negedge clk);
      hif.rd_en = 1'b1;
      hif.rd_sel = sel;
      hif.rd_idx = idx;
      e.data = exp;
      e.chg = chg;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
      hif.rd_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // Pulses scan_start; k counts negedges after the start edge until scan_done is seen.
   task automatic run_pass(output int k);
      @(negedge clk);
      scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
      k = 0;
      while (scan_done !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 1000) check("pass_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_rf_addr(input logic [4:0] a);
      int n;
      n = 0;
      while (!(busy === 1'b1 && rf_addr === a) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("wait_rf_addr_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int k;
      int c;
      int ndone;
      int last_done;
      int first_done;
      int low_cycles;
      int bad_gaps;
      int spurious;

      hif.rd_en = 1'b0;
      hif.rd_sel = 1'b0;
      hif.rd_idx = 5'd0;
      for (int i = 0; i < 32; i++) rf_model[i] = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < MW; i++) mem_model[i] = ~32'(i);

      // 1: reset then idle
      do_reset();
      repeat (10) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, scan_done}, 32'd0);
      check("reset_rf_addr", {27'd0, rf_addr}, 32'd0);
      check("reset_mem_addr", mem_addr, BASE);
      check("reset_count", {16'd0, scan_count}, 32'd0);
      check("reset_snap", {29'd0, snap_state}, 32'd0);
      check("reset_rd_valid", {31'd0, hif.rd_valid}, 32'd0);
      host_read(1'b0, 5'd0, 32'h0, 1'b0, "reset_buf_rf0");

      // 2: single pass, timing and readback
      display_state = 3'd5;
      run_pass(k);
      check("pass_len", 32'(k + 1), 32'(PASS_LEN));
      check("pass_count", {16'd0, scan_count}, 32'd1);
      check("pass_snap", {29'd0, snap_state}, 32'd5);
      @(negedge clk);
      check("pass_done_one_cycle", {31'd0, scan_done}, 32'd0);
      host_read(1'b0, 5'd8, 32'hA000_0008, 1'b1, "rd_rf8");
      host_read(1'b1, 5'd3, 32'hFFFF_FFFC, 1'b1, "rd_mem3");
      host_read(1'b0, 5'd31, 32'hA000_001F, 1'b1, "rd_rf31");
      host_read(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, "rd_mem0");

      // 3: continuous scanning with ignored scan_start pulses
      do_reset();
      @(negedge clk);
      scan_cont = 1'b1;
      ndone = 0; last_done = 0; first_done = -1; low_cycles = 0; bad_gaps = 0;
      for (c = 0; c < 600 && ndone < 3; c++) begin
         @(negedge clk);
         scan_start = (c == 40 || c == 200);
         if (ndone == 2 && c > last_done + 10) scan_cont = 1'b0;
         if (busy !== 1'b1) low_cycles++;
         if (scan_done === 1'b1) begin
            if (ndone == 0) first_done = c;
            else if (c - last_done != PASS_LEN) bad_gaps++;
            last_done = c;
            ndone++;
            if (ndone == 3) low_cycles--;
         end
      end
      scan_start = 1'b0;
      scan_cont = 1'b0;
      check("cont_passes", 32'(ndone), 32'd3);
      check("cont_first_len", 32'(first_done + 1), 32'(PASS_LEN));
      check("cont_bad_gaps", 32'(bad_gaps), 32'd0);
      check("cont_idle_cycles", 32'(low_cycles), 32'd2);
      repeat (20) @(negedge clk);
      check("cont_stopped_busy", {31'd0, busy}, 32'd0);
      check("cont_count", {16'd0, scan_count}, 32'd3);

      // 4: reset in the middle of the register scan
      display_state = 3'd6;
      @(negedge clk);
      scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
      wait_rf_addr(5'd10);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_count", {16'd0, scan_count}, 32'd0);
      check("abort_rf_addr", {27'd0, rf_addr}, 32'd0);
      check("abort_mem_addr", mem_addr, BASE);
      check("abort_snap", {29'd0, snap_state}, 32'd0);
      spurious = 0;
      repeat (200) begin
         @(negedge clk);
         if (scan_done !== 1'b0 || busy !== 1'b0) spurious++;
      end
      check("abort_quiet", 32'(spurious), 32'd0);
      host_read(1'b0, 5'd0, 32'h0, 1'b0, "abort_rf0");
      host_read(1'b0, 5'd5, 32'h0, 1'b0, "abort_rf5");
      host_read(1'b0, 5'd9, 32'h0, 1'b0, "abort_rf9");
      host_read(1'b0, 5'd31, 32'h0, 1'b0, "abort_rf31");
      host_read(1'b1, 5'd7, 32'h0, 1'b0, "abort_mem7");

      // 5: out-of-range memory reads and read-before-write
      display_state = 3'd2;
      run_pass(k);
      check("p5_snap", {29'd0, snap_state}, 32'd2);
      host_read(1'b1, 5'd20, 32'h0, 1'b0, "rd_mem20");
      host_read(1'b1, 5'd8, 32'h0, 1'b0, "rd_mem8");
      host_read(1'b1, 5'd7, 32'hFFFF_FFF8, 1'b1, "rd_mem7");
      host_read(1'b0, 5'd12, 32'hA000_000C, 1'b1, "rd_rf12");
      rf_model[12] = 32'h1234_5678;
      @(negedge clk);
      scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
      wait_rf_addr(5'd12);
      @(negedge clk);
      host_read(1'b0, 5'd12, 32'hA000_000C, 1'b0, "rbw_rf12_old");
      k = 0;
      while (scan_done !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 1000) check("p5_timeout", 32'd1, 32'd0);
      host_read(1'b0, 5'd12, 32'h1234_5678, 1'b1, "rbw_rf12_new");

`ifdef CHANGE_FLAG_EN
      // 6: change flags
      host_read(1'b0, 5'd5, 32'hA000_0005, 1'b1, "chg_rf5_pre");
      host_read(1'b0, 5'd6, 32'hA000_0006, 1'b1, "chg_rf6_pre");
      rf_model[5] = 32'hCAFE_0005;
      run_pass(k);
      host_read(1'b0, 5'd5, 32'hCAFE_0005, 1'b1, "chg_rf5_first");
      host_read(1'b0, 5'd5, 32'hCAFE_0005, 1'b0, "chg_rf5_second");
      host_read(1'b0, 5'd6, 32'hA000_0006, 1'b0, "chg_rf6");
`endif

      repeat (5) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
